if_stage_pipe: RTL and testbench

Instruction-fetch stage with the IF/ID pipeline register. It drives the instruction-memory address and latches fetched instructions into IF/ID, and it presents the rs1/rs2 fields directly to the hazard detection unit. It obeys that unit's PCWrite/IF_ID_Write stall controls and the EX-stage branch redirect/flush. Saturating stall and flush counters support pipeline performance debug.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/sat_counter.sv | 25 ++
 rtl/if_stage_pipe.sv | 99 +++++++++
 tb/tb_if_stage_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and helpers for the fetch/decode boundary.
//   XLEN      : default datapath/address width
//   NOP_INSTR : canonical bubble instruction (addi x0, x0, 0)
//   RS1_LSB / RS2_LSB / FIELD_W : register-source field positions in an instruction
package pipeline_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned FIELD_W   = 5;
    localparam int unsigned RS1_LSB   = 15;
    localparam int unsigned RS2_LSB   = 20;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Extract a 5-bit register specifier starting at bit lsb.
    function automatic logic [FIELD_W-1:0] reg_field(
        input logic [INSTR_W-1:0] instr,
        input int unsigned        lsb
    );
        return instr[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance debug.
//   clk   : clock
//   rst_n : synchronous active-low clear
//   inc   : increment request for this cycle
//   count : current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage plus IF/ID pipeline register.
//   clk, rst_n            : clock, synchronous active-low reset
//   PCWrite, IF_ID_Write  : hazard-unit stall controls (0 = hold)
//   branch_taken/_target  : EX-stage redirect; flushes IF/ID
//   imem_addr/imem_rdata  : instruction memory (combinational read)
//   IF_ID_*               : pipeline register contents toward ID / hazard unit
//   stall_count/flush_count : saturating performance counters
module if_stage_pipe #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [XLEN-1:0]  IF_ID_PC,
    output logic [XLEN-1:0]  IF_ID_PCPlus4,
    output logic [31:0]      IF_ID_Instr,
    output logic             IF_ID_Valid,
    output logic [4:0]       IF_ID_RegisterRs1,
    output logic [4:0]       IF_ID_RegisterRs2,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    import pipeline_pkg::NOP_INSTR;
    import pipeline_pkg::RS1_LSB;
    import pipeline_pkg::RS2_LSB;
    import pipeline_pkg::reg_field;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] if_pc_q;
    logic [31:0]     if_instr_q;
    logic            if_valid_q;
    logic            stall_inc_c;
    logic            flush_inc_c;

    // A redirect flushes IF/ID, so a simultaneous IF/ID hold is not a stall.
    always_comb begin
        flush_inc_c = branch_taken;
        stall_inc_c = 1'b0;
        if (!branch_taken && !IF_ID_Write) begin
            stall_inc_c = 1'b1;
        end
    end

    // PC and IF/ID register; the redirect outranks both hazard holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
        end else if (branch_taken) begin
            pc_q       <= {branch_target[XLEN-1:2], 2'b00};
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
        end else begin
            if (PCWrite) begin
                pc_q <= pc_q + XLEN'(4);
            end
            if (IF_ID_Write) begin
                if_pc_q    <= pc_q;
                if_instr_q <= imem_rdata;
                if_valid_q <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_c),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_c),
        .count (flush_count)
    );

    // Bubble holds NOP, whose rs fields are zero, so it never matches a real rd.
    assign imem_addr         = pc_q;
    assign IF_ID_PC          = if_pc_q;
    assign IF_ID_PCPlus4     = if_pc_q + XLEN'(4);
    assign IF_ID_Instr       = if_instr_q;
    assign IF_ID_Valid       = if_valid_q;
    assign IF_ID_RegisterRs1 = reg_field(if_instr_q, RS1_LSB);
    assign IF_ID_RegisterRs2 = reg_field(if_instr_q, RS2_LSB);

endmodule

// File: tb/tb_if_stage_pipe.sv
// Scoreboard bench for if_stage_pipe: two instances (default parameters, and
// RESET_PC near the top of memory with 2-bit counters) share one stimulus stream.
module tb_if_stage_pipe;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] stall;
        logic [15:0] flush;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcw;
    logic        ifw;
    logic        bt;
    logic [31:0] tgt;

    logic [31:0] a_addr, a_rdata, a_ifpc, a_pc4, a_instr;
    logic        a_valid;
    logic [4:0]  a_rs1, a_rs2;
    logic [15:0] a_stall, a_flush;

    logic [31:0] b_addr, b_rdata, b_ifpc, b_pc4, b_instr;
    logic        b_valid;
    logic [4:0]  b_rs1, b_rs2;
    logic [1:0]  b_stall, b_flush;

    int n_checks = 0;
    int n_errors = 0;

    obs_t q0[$];
    obs_t q1[$];

    // Reference model state, one slot per instance
    logic [31:0] m_pc[2];
    logic [31:0] m_ifpc[2];
    logic [31:0] m_instr[2];
    logic        m_valid[2];
    int unsigned m_stall[2];
    int unsigned m_flush[2];
    logic [31:0] m_rpc[2];
    int unsigned m_cmax[2];

    always #5 clk = ~clk;

    // Address-derived instruction memory contents
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    assign a_rdata = imem_word(a_addr);
    assign b_rdata = imem_word(b_addr);

    if_stage_pipe u_dut_a (
        .clk               (clk),
        .rst_n             (rst_n),
        .PCWrite           (pcw),
        .IF_ID_Write       (ifw),
        .branch_taken      (bt),
        .branch_target     (tgt),
        .imem_addr         (a_addr),
        .imem_rdata        (a_rdata),
        .IF_ID_PC          (a_ifpc),
        .IF_ID_PCPlus4     (a_pc4),
        .IF_ID_Instr       (a_instr),
        .IF_ID_Valid       (a_valid),
        .IF_ID_RegisterRs1 (a_rs1),
        .IF_ID_RegisterRs2 (a_rs2),
        .stall_count       (a_stall),
        .flush_count       (a_flush)
    );

    if_stage_pipe #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) u_dut_b (
        .clk               (clk),
        .rst_n             (rst_n),
        .PCWrite           (pcw),
        .IF_ID_Write       (ifw),
        .branch_taken      (bt),
        .branch_target     (tgt),
        .imem_addr         (b_addr),
        .imem_rdata        (b_rdata),
        .IF_ID_PC          (b_ifpc),
        .IF_ID_PCPlus4     (b_pc4),
        .IF_ID_Instr       (b_instr),
        .IF_ID_Valid       (b_valid),
        .IF_ID_RegisterRs1 (b_rs1),
        .IF_ID_RegisterRs2 (b_rs2),
        .stall_count       (b_stall),
        .flush_count       (b_flush)
    );

    obs_t act0, act1;
    assign act0 = {a_addr, a_ifpc, a_pc4, a_instr, a_valid, a_rs1, a_rs2, a_stall, a_flush};
    assign act1 = {b_addr, b_ifpc, b_pc4, b_instr, b_valid, b_rs1, b_rs2,
                   16'(b_stall), 16'(b_flush)};

    // Advance model k by one clock edge and queue the state it must show afterwards.
    task automatic model_step(input int k);
        obs_t        e;
        logic [31:0] ins;
        if (!rst_n) begin
            m_pc[k]    = m_rpc[k];
            m_ifpc[k]  = 32'h0;
            m_instr[k] = 32'h0000_0013;
            m_valid[k] = 1'b0;
            m_stall[k] = 0;
            m_flush[k] = 0;
        end else if (bt) begin
            m_pc[k]    = tgt & ~32'd3;
            m_ifpc[k]  = 32'h0;
            m_instr[k] = 32'h0000_0013;
            m_valid[k] = 1'b0;
            if (m_flush[k] < m_cmax[k]) m_flush[k] = m_flush[k] + 1;
        end else begin
            if (ifw) begin
                m_ifpc[k]  = m_pc[k];
                m_instr[k] = imem_word(m_pc[k]);
                m_valid[k] = 1'b1;
            end else if (m_stall[k] < m_cmax[k]) begin
                m_stall[k] = m_stall[k] + 1;
            end
            if (pcw) m_pc[k] = m_pc[k] + 32'd4;
        end
        ins     = m_instr[k];
        e.addr  = m_pc[k];
        e.pc    = m_ifpc[k];
        e.pc4   = m_ifpc[k] + 32'd4;
        e.instr = ins;
        e.valid = m_valid[k];
        e.rs1   = ins[19:15];
        e.rs2   = ins[24:20];
        e.stall = 16'(m_stall[k]);
        e.flush = 16'(m_flush[k]);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic cmp(input int k, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    task automatic compare(input int k, input obs_t e, input obs_t a);
        cmp(k, "imem_addr",   a.addr,        e.addr);
        cmp(k, "IF_ID_PC",    a.pc,          e.pc);
        cmp(k, "PCPlus4",     a.pc4,         e.pc4);
        cmp(k, "IF_ID_Instr", a.instr,       e.instr);
        cmp(k, "IF_ID_Valid", 32'(a.valid),  32'(e.valid));
        cmp(k, "rs1",         32'(a.rs1),    32'(e.rs1));
        cmp(k, "rs2",         32'(a.rs2),    32'(e.rs2));
        cmp(k, "stall_count", 32'(a.stall),  32'(e.stall));
        cmp(k, "flush_count", 32'(a.flush),  32'(e.flush));
    endtask

    // Monitor: each edge produces one observation per instance
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() != 0) compare(0, q0.pop_front(), act0);
            if (q1.size() != 0) compare(1, q1.pop_front(), act1);
        end
    end

    task automatic drive(input logic r, input logic p, input logic w, input logic b,
                         input logic [31:0] t, input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n = r;
            pcw   = p;
            ifw   = w;
            bt    = b;
            tgt   = t;
            model_step(0);
            model_step(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned sel;
        logic        r, p, w, b;
        m_rpc[0]  = 32'h0;
        m_rpc[1]  = 32'hFFFF_FFF8;
        m_cmax[0] = 65535;
        m_cmax[1] = 3;
        rst_n = 1'b0;
        pcw   = 1'b1;
        ifw   = 1'b1;
        bt    = 1'b0;
        tgt   = 32'h0;

        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   2);  // reset
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   2);  // free run to PC=8
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1);  // load-use stall
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   2);  // resume to PC=16
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1);  // branch
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   2);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h203, 1);  // branch during stall, misaligned
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   5);  // saturates 2-bit counter
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1);  // fetched word dropped
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1);  // reload same PC
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40,  1);  // reset mid-stall and mid-redirect
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   4);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 99);
            r = ($urandom_range(0, 99) >= 3);
            p = 1'b1;
            w = 1'b1;
            if (sel < 20) begin
                p = 1'b0;
                w = 1'b0;
            end else if (sel < 23) begin
                w = 1'b0;
            end else if (sel < 26) begin
                p = 1'b0;
            end
            b = ($urandom_range(0, 99) < 10);
            drive(r, p, w, b, $urandom, 1);
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (q0.size() + q1.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d observations outstanding, expected 0",
                     q0.size() + q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
